// File: rtl/apb2axi_pkg.sv
// Shared types and widths for the APB-to-AXI bridge.
// Provides the write-data FIFO entry, the AW issue record, the W scheduler
// state encoding and the default order-queue depth.
// Optional feature macro used by the W scheduler: APB2AXI_W_TAG_CHECK_EN.
package apb2axi_pkg;

    localparam int unsigned TAG_W      = 4;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
    localparam int unsigned AXI_LEN_W  = 8;
    localparam int unsigned W_OQ_DEPTH = 4;

    // Packed write beat as produced by the packer (last is always 0 there).
    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic                  last;
        logic [AXI_STRB_W-1:0] wstrb;
        logic [AXI_DATA_W-1:0] data;
    } wr_entry_t;

    localparam int unsigned DATA_ENTRY_W = $bits(wr_entry_t);

    // Record of one issued AW burst.
    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [AXI_LEN_W-1:0] len;
    } aw_evt_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } w_sched_state_e;

endpackage

// File: rtl/apb2axi_w_order_fifo.sv
// Small synchronous FIFO holding AW issue records in issue order.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   push_i / push_data_i   : write a record (ignored when full)
//   pop_i / pop_data_o     : drop the head record (ignored when empty); head is
//                            always visible on pop_data_o
//   full_o, empty_o        : status from registered pointers (no bypass)
module apb2axi_w_order_fifo
    import apb2axi_pkg::*;
#(
    parameter int unsigned DEPTH   = W_OQ_DEPTH,
    parameter type         entry_t = aw_evt_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t pop_data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned PTR_W_X = PTR_W + 1;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0] wptr_q, rptr_q;
    entry_t         mem_q [DEPTH];
    logic           do_push, do_pop;

    assign full_o  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign pop_data_o = mem_q[rptr_q[PTR_W-1:0]];

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_W_X'(1);
            if (do_pop)  rptr_q <= rptr_q + PTR_W_X'(1);
        end
    end

    // Storage; contents are only observed while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[PTR_W-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/apb2axi_w_sched.sv
// AXI W-channel scheduler for the APB-to-AXI bridge.
// Records each AW issue (tag, LEN) in an order queue, pops packed beats from
// the write-data FIFO into a single W output register in AW issue order,
// generates WLAST from LEN and reports per-burst completion.
// Ports:
//   pclk, preset                     : clock, asynchronous active-high reset
//   aw_evt_vld/tag/len, aw_evt_rdy   : AW issue record input
//   wdf_pop_vld/payload, wdf_pop_rdy : write-data FIFO head and pop
//   m_axi_w*                         : AXI W channel master
//   wr_done_vld/tag                  : last beat of a burst accepted
//   busy                             : burst active, queue non-empty or beat held
//   err_mismatch, err_clr            : sticky tag-mismatch flag and clear
// Optional: define APB2AXI_W_TAG_CHECK_EN to drop beats whose tag differs from
// the active burst and flag them on err_mismatch (otherwise tied 0).
module apb2axi_w_sched
    import apb2axi_pkg::*;
#(
    parameter int unsigned OQ_DEPTH = W_OQ_DEPTH,
    parameter int unsigned LEN_W    = AXI_LEN_W
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    aw_evt_vld,
    input  logic [TAG_W-1:0]        aw_evt_tag,
    input  logic [LEN_W-1:0]        aw_evt_len,
    output logic                    aw_evt_rdy,
    input  logic                    wdf_pop_vld,
    input  logic [DATA_ENTRY_W-1:0] wdf_pop_payload,
    output logic                    wdf_pop_rdy,
    output logic                    m_axi_wvalid,
    output logic [AXI_DATA_W-1:0]   m_axi_wdata,
    output logic [AXI_STRB_W-1:0]   m_axi_wstrb,
    output logic                    m_axi_wlast,
    input  logic                    m_axi_wready,
    output logic                    wr_done_vld,
    output logic [TAG_W-1:0]        wr_done_tag,
    output logic                    busy,
    output logic                    err_mismatch,
    input  logic                    err_clr
);

    localparam int unsigned CNT_W = LEN_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [LEN_W-1:0] len;
    } aw_rec_t;

    w_sched_state_e        state_q, state_d;
    logic [TAG_W-1:0]      cur_tag_q, cur_tag_d;
    logic [LEN_W-1:0]      cur_len_q, cur_len_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [TAG_W-1:0]      w_tag_q, w_tag_d;
    logic                  wvalid_q, wvalid_d;
    logic                  wlast_q, wlast_d;
    logic [AXI_DATA_W-1:0] wdata_q, wdata_d;
    logic [AXI_STRB_W-1:0] wstrb_q, wstrb_d;

    aw_rec_t   push_rec, head_rec;
    logic      oq_full, oq_empty, oq_pop;
    wr_entry_t head_beat;
    logic      out_free, w_hs, beats_left, tag_bad, pop_beat, drop_beat;
    logic [CNT_W-1:0] cnt_next;
    logic      unused_bits;

    assign push_rec  = '{tag: aw_evt_tag, len: aw_evt_len};
    assign head_beat = wr_entry_t'(wdf_pop_payload);

    apb2axi_w_order_fifo #(
        .DEPTH   (OQ_DEPTH),
        .entry_t (aw_rec_t)
    ) u_order_fifo (
        .clk         (pclk),
        .rst         (preset),
        .push_i      (aw_evt_vld),
        .push_data_i (push_rec),
        .pop_i       (oq_pop),
        .pop_data_o  (head_rec),
        .full_o      (oq_full),
        .empty_o     (oq_empty)
    );

    assign aw_evt_rdy = !oq_full;
    assign out_free   = !wvalid_q || m_axi_wready;
    assign w_hs       = wvalid_q && m_axi_wready;
    // Beats of the active burst still to be taken from the data FIFO.
    assign beats_left = (state_q == BURST) && (beat_cnt_q <= CNT_W'(cur_len_q));

`ifdef APB2AXI_W_TAG_CHECK_EN
    assign tag_bad = (head_beat.tag != cur_tag_q);
`else
    assign tag_bad = 1'b0;
`endif

    // Mismatching beats are discarded without needing the output register.
    assign drop_beat   = wdf_pop_vld && beats_left && tag_bad;
    assign pop_beat    = wdf_pop_vld && beats_left && !tag_bad && out_free;
    assign wdf_pop_rdy = pop_beat || drop_beat;
    assign cnt_next    = beat_cnt_q + CNT_W'(pop_beat);

    assign unused_bits = ^{head_beat.last, head_beat.tag, err_clr};

    // Next-state and output-register logic.
    always_comb begin
        state_d    = state_q;
        cur_tag_d  = cur_tag_q;
        cur_len_d  = cur_len_q;
        beat_cnt_d = beat_cnt_q;
        w_tag_d    = w_tag_q;
        wvalid_d   = wvalid_q;
        wlast_d    = wlast_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        oq_pop     = 1'b0;

        if (pop_beat) begin
            wvalid_d = 1'b1;
            wdata_d  = head_beat.data;
            wstrb_d  = head_beat.wstrb;
            wlast_d  = (beat_cnt_q == CNT_W'(cur_len_q));
            w_tag_d  = cur_tag_q;
        end else if (w_hs) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!oq_empty) begin
                    oq_pop     = 1'b1;
                    cur_tag_d  = head_rec.tag;
                    cur_len_d  = head_rec.len;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                beat_cnt_d = cnt_next;
                // Once every beat is fetched, switch to the next record early so
                // the following burst streams without a bubble; the held beat
                // keeps its own tag in w_tag_q for the done report.
                if (cnt_next > CNT_W'(cur_len_q)) begin
                    if (!oq_empty) begin
                        oq_pop     = 1'b1;
                        cur_tag_d  = head_rec.tag;
                        cur_len_d  = head_rec.len;
                        beat_cnt_d = '0;
                    end else if (w_hs && wlast_q && !pop_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef APB2AXI_W_TAG_CHECK_EN
    logic err_q, err_d;

    // Sticky mismatch flag; a new mismatch beats a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (drop_beat)    err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
    end

    assign err_mismatch = err_q;
`else
    assign err_mismatch = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q    <= IDLE;
            cur_tag_q  <= '0;
            cur_len_q  <= '0;
            beat_cnt_q <= '0;
            w_tag_q    <= '0;
            wvalid_q   <= 1'b0;
            wlast_q    <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
`ifdef APB2AXI_W_TAG_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cur_tag_q  <= cur_tag_d;
            cur_len_q  <= cur_len_d;
            beat_cnt_q <= beat_cnt_d;
            w_tag_q    <= w_tag_d;
            wvalid_q   <= wvalid_d;
            wlast_q    <= wlast_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
`ifdef APB2AXI_W_TAG_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign m_axi_wvalid = wvalid_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = wstrb_q;
    assign m_axi_wlast  = wlast_q;
    assign wr_done_vld  = w_hs && wlast_q;
    assign wr_done_tag  = w_tag_q;
    assign busy         = (state_q == BURST) || !oq_empty || wvalid_q;

endmodule

// File: tb/tb_apb2axi_w_sched.sv
// Self-checking bench for apb2axi_w_sched: a cycle table for single and
// back-to-back bursts, plus hand-written backpressure, order-queue-full,
// reset-mid-burst and tag-check sequences.
module tb_apb2axi_w_sched;
    import apb2axi_pkg::*;

    logic                    pclk = 1'b0;
    logic                    preset;
    logic                    aw_evt_vld;
    logic [TAG_W-1:0]        aw_evt_tag;
    logic [AXI_LEN_W-1:0]    aw_evt_len;
    logic                    aw_evt_rdy;
    logic                    wdf_pop_vld;
    wr_entry_t               wdf_pop_payload;
    logic                    wdf_pop_rdy;
    logic                    m_axi_wvalid;
    logic [AXI_DATA_W-1:0]   m_axi_wdata;
    logic [AXI_STRB_W-1:0]   m_axi_wstrb;
    logic                    m_axi_wlast;
    logic                    m_axi_wready;
    logic                    wr_done_vld;
    logic [TAG_W-1:0]        wr_done_tag;
    logic                    busy;
    logic                    err_mismatch;
    logic                    err_clr;

    int n_tests = 0;
    int n_fail  = 0;

    wr_entry_t beat_q[$];
    wr_entry_t exp_q[$];

    apb2axi_w_sched dut (
        .pclk            (pclk),
        .preset          (preset),
        .aw_evt_vld      (aw_evt_vld),
        .aw_evt_tag      (aw_evt_tag),
        .aw_evt_len      (aw_evt_len),
        .aw_evt_rdy      (aw_evt_rdy),
        .wdf_pop_vld     (wdf_pop_vld),
        .wdf_pop_payload (wdf_pop_payload),
        .wdf_pop_rdy     (wdf_pop_rdy),
        .m_axi_wvalid    (m_axi_wvalid),
        .m_axi_wdata     (m_axi_wdata),
        .m_axi_wstrb     (m_axi_wstrb),
        .m_axi_wlast     (m_axi_wlast),
        .m_axi_wready    (m_axi_wready),
        .wr_done_vld     (wr_done_vld),
        .wr_done_tag     (wr_done_tag),
        .busy            (busy),
        .err_mismatch    (err_mismatch),
        .err_clr         (err_clr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        aw_v;
        logic [3:0]  aw_tag;
        logic [7:0]  aw_len;
        logic        wd_v;
        logic [3:0]  wd_tag;
        logic [31:0] wd_data;
        logic        wready;
        logic        e_awrdy;
        logic        e_poprdy;
        logic        e_wv;
        logic [31:0] e_wdata;
        logic        e_wlast;
        logic        e_done;
        logic [3:0]  e_dtag;
        logic        e_busy;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mkv(logic aw_v, logic [3:0] aw_tag, logic [7:0] aw_len,
                                 logic wd_v, logic [3:0] wd_tag, logic [31:0] wd_data,
                                 logic wready, logic e_awrdy, logic e_poprdy, logic e_wv,
                                 logic [31:0] e_wdata, logic e_wlast, logic e_done,
                                 logic [3:0] e_dtag, logic e_busy);
        vec_t v;
        v.aw_v = aw_v; v.aw_tag = aw_tag; v.aw_len = aw_len;
        v.wd_v = wd_v; v.wd_tag = wd_tag; v.wd_data = wd_data; v.wready = wready;
        v.e_awrdy = e_awrdy; v.e_poprdy = e_poprdy; v.e_wv = e_wv; v.e_wdata = e_wdata;
        v.e_wlast = e_wlast; v.e_done = e_done; v.e_dtag = e_dtag; v.e_busy = e_busy;
        return v;
    endfunction

    function automatic wr_entry_t mk_beat(logic [3:0] tag, logic [31:0] data, logic [3:0] strb);
        wr_entry_t b;
        b.tag = tag; b.last = 1'b0; b.wstrb = strb; b.data = data;
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic idle_inputs();
        aw_evt_vld = 1'b0; aw_evt_tag = '0; aw_evt_len = '0;
        wdf_pop_vld = 1'b0; wdf_pop_payload = '0;
        m_axi_wready = 1'b1; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        preset = 1'b1;
        idle_inputs();
        beat_q.delete();
        exp_q.delete();
        tick();
        tick();
        preset = 1'b0;
    endtask

    task automatic push_aw(input logic [3:0] tag, input logic [7:0] len);
        aw_evt_vld = 1'b1; aw_evt_tag = tag; aw_evt_len = len;
        wdf_pop_vld = 1'b0; m_axi_wready = 1'b1;
        #1;
        chk("push_aw_rdy", 64'(aw_evt_rdy), 64'(1));
        tick();
        aw_evt_vld = 1'b0;
    endtask

    // Streams beat_q into the DUT and checks every accepted beat against exp_q.
    task automatic run_stream(input int n_exp, input logic [3:0] tag, input bit toggle);
        int acc = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [31:0] pd = '0;
        logic pl = 1'b0;
        while (acc < n_exp && cyc < 200) begin
            m_axi_wready = toggle ? cyc[0] : 1'b1;
            wdf_pop_vld = (beat_q.size() > 0);
            wdf_pop_payload = (beat_q.size() > 0) ? beat_q[0] : '0;
            #1;
            if (stalled) begin
                chk("stall_valid", 64'(m_axi_wvalid), 64'(1));
                chk("stall_data", 64'(m_axi_wdata), 64'(pd));
                chk("stall_last", 64'(m_axi_wlast), 64'(pl));
            end
            if (m_axi_wvalid && !m_axi_wready)
                chk("no_pop_stalled", 64'(wdf_pop_rdy), 64'(0));
            if (m_axi_wvalid && m_axi_wready) begin
                chk("beat_data", 64'(m_axi_wdata), 64'(exp_q[acc].data));
                chk("beat_strb", 64'(m_axi_wstrb), 64'(exp_q[acc].wstrb));
                chk("beat_last", 64'(m_axi_wlast), 64'(acc == n_exp - 1));
                chk("beat_done", 64'(wr_done_vld), 64'(acc == n_exp - 1));
                if (acc == n_exp - 1) chk("done_tag", 64'(wr_done_tag), 64'(tag));
                acc++;
            end else begin
                chk("no_done", 64'(wr_done_vld), 64'(0));
            end
            stalled = m_axi_wvalid && !m_axi_wready;
            pd = m_axi_wdata;
            pl = m_axi_wlast;
            if (wdf_pop_rdy && beat_q.size() > 0) void'(beat_q.pop_front());
            tick();
            cyc++;
        end
        chk("accepted_beats", 64'(acc), 64'(n_exp));
        wdf_pop_vld = 1'b0;
        m_axi_wready = 1'b1;
        #1;
        chk("no_extra_beat", 64'(m_axi_wvalid), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        int acc;

        // Reset values.
        preset = 1'b1;
        idle_inputs();
        #1;
        chk("rst_aw_rdy", 64'(aw_evt_rdy), 64'(1));
        chk("rst_pop_rdy", 64'(wdf_pop_rdy), 64'(0));
        chk("rst_wvalid", 64'(m_axi_wvalid), 64'(0));
        chk("rst_wlast", 64'(m_axi_wlast), 64'(0));
        chk("rst_done", 64'(wr_done_vld), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err_mismatch), 64'(0));
        tick();
        preset = 1'b0;

        // Single burst (tag 3, len 0) then back-to-back bursts (1,len3),(2,len1).
        //               awv tg ln wdv wt data          rdy | ard prd wv wdata       wl dn dt busy
        vecs[0]  = mkv(1, 3, 0, 1, 3, 32'hA5A5A5A5, 1,   1, 0, 0, 32'h0,        0, 0, 0, 0);
        vecs[1]  = mkv(0, 0, 0, 1, 3, 32'hA5A5A5A5, 1,   1, 0, 0, 32'h0,        0, 0, 0, 1);
        vecs[2]  = mkv(0, 0, 0, 1, 3, 32'hA5A5A5A5, 1,   1, 1, 0, 32'h0,        0, 0, 0, 1);
        vecs[3]  = mkv(0, 0, 0, 0, 0, 32'h0,        1,   1, 0, 1, 32'hA5A5A5A5, 1, 1, 3, 1);
        vecs[4]  = mkv(0, 0, 0, 0, 0, 32'h0,        1,   1, 0, 0, 32'h0,        0, 0, 0, 0);
        vecs[5]  = mkv(1, 1, 3, 1, 1, 32'hB0000001, 1,   1, 0, 0, 32'h0,        0, 0, 0, 0);
        vecs[6]  = mkv(1, 2, 1, 1, 1, 32'hB0000001, 1,   1, 0, 0, 32'h0,        0, 0, 0, 1);
        vecs[7]  = mkv(0, 0, 0, 1, 1, 32'hB0000001, 1,   1, 1, 0, 32'h0,        0, 0, 0, 1);
        vecs[8]  = mkv(0, 0, 0, 1, 1, 32'hB0000002, 1,   1, 1, 1, 32'hB0000001, 0, 0, 0, 1);
        vecs[9]  = mkv(0, 0, 0, 1, 1, 32'hB0000003, 1,   1, 1, 1, 32'hB0000002, 0, 0, 0, 1);
        vecs[10] = mkv(0, 0, 0, 1, 1, 32'hB0000004, 1,   1, 1, 1, 32'hB0000003, 0, 0, 0, 1);
        vecs[11] = mkv(0, 0, 0, 1, 2, 32'hB0000005, 1,   1, 1, 1, 32'hB0000004, 1, 1, 1, 1);
        vecs[12] = mkv(0, 0, 0, 1, 2, 32'hB0000006, 1,   1, 1, 1, 32'hB0000005, 0, 0, 0, 1);
        vecs[13] = mkv(0, 0, 0, 0, 0, 32'h0,        1,   1, 0, 1, 32'hB0000006, 1, 1, 2, 1);
        vecs[14] = mkv(0, 0, 0, 0, 0, 32'h0,        1,   1, 0, 0, 32'h0,        0, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            aw_evt_vld = vecs[i].aw_v;
            aw_evt_tag = vecs[i].aw_tag;
            aw_evt_len = vecs[i].aw_len;
            wdf_pop_vld = vecs[i].wd_v;
            wdf_pop_payload = mk_beat(vecs[i].wd_tag, vecs[i].wd_data, 4'hF);
            m_axi_wready = vecs[i].wready;
            #1;
            chk($sformatf("v%0d_aw_rdy", i), 64'(aw_evt_rdy), 64'(vecs[i].e_awrdy));
            chk($sformatf("v%0d_pop_rdy", i), 64'(wdf_pop_rdy), 64'(vecs[i].e_poprdy));
            chk($sformatf("v%0d_wvalid", i), 64'(m_axi_wvalid), 64'(vecs[i].e_wv));
            if (vecs[i].e_wv) begin
                chk($sformatf("v%0d_wdata", i), 64'(m_axi_wdata), 64'(vecs[i].e_wdata));
                chk($sformatf("v%0d_wlast", i), 64'(m_axi_wlast), 64'(vecs[i].e_wlast));
            end
            chk($sformatf("v%0d_done", i), 64'(wr_done_vld), 64'(vecs[i].e_done));
            if (vecs[i].e_done)
                chk($sformatf("v%0d_done_tag", i), 64'(wr_done_tag), 64'(vecs[i].e_dtag));
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
            tick();
        end

        // Backpressure: len 7 burst, wready toggling every cycle.
        do_reset();
        push_aw(4, 7);
        for (int k = 0; k < 8; k++) begin
            beat_q.push_back(mk_beat(4, 32'hC0DE0000 + 32'(k), 4'(k + 1)));
            exp_q.push_back(mk_beat(4, 32'hC0DE0000 + 32'(k), 4'(k + 1)));
        end
        run_stream(8, 4, 1'b1);

        // Order-queue full: one burst waiting for data, then five more AWs.
        do_reset();
        push_aw(7, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            aw_evt_vld = 1'b1; aw_evt_tag = 4'(k + 1); aw_evt_len = '0;
            #1;
            chk("oq_fill_rdy", 64'(aw_evt_rdy), 64'(1));
            tick();
        end
        aw_evt_tag = 4'd5;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("oq_full_rdy", 64'(aw_evt_rdy), 64'(0));
            chk("oq_full_busy", 64'(busy), 64'(1));
            tick();
        end
        wdf_pop_vld = 1'b1;
        wdf_pop_payload = mk_beat(7, 32'h77777777, 4'hF);
        m_axi_wready = 1'b1;
        #1;
        chk("oq_x_pop", 64'(wdf_pop_rdy), 64'(1));
        chk("oq_x_still_full", 64'(aw_evt_rdy), 64'(0));
        tick();
        wdf_pop_vld = 1'b0;
        #1;
        chk("oq_slot_freed", 64'(aw_evt_rdy), 64'(1));
        chk("oq_x_wvalid", 64'(m_axi_wvalid), 64'(1));
        chk("oq_x_wlast", 64'(m_axi_wlast), 64'(1));
        chk("oq_x_done", 64'(wr_done_vld), 64'(1));
        chk("oq_x_done_tag", 64'(wr_done_tag), 64'(7));
        tick();
        aw_evt_vld = 1'b0;
        #1;
        chk("oq_fifth_taken", 64'(aw_evt_rdy), 64'(0));
        chk("oq_no_beat", 64'(m_axi_wvalid), 64'(0));

        // Reset in the middle of a len 3 burst, then a fresh burst.
        do_reset();
        push_aw(2, 3);
        for (int k = 0; k < 4; k++) beat_q.push_back(mk_beat(2, 32'hD0000000 + 32'(k), 4'hF));
        hit = 0;
        acc = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            m_axi_wready = 1'b1;
            wdf_pop_vld = (beat_q.size() > 0);
            wdf_pop_payload = (beat_q.size() > 0) ? beat_q[0] : '0;
            #1;
            if (m_axi_wvalid && acc == 1) begin
                hit = 1;
                preset = 1'b1;
                #1;
                chk("mid_rst_wvalid", 64'(m_axi_wvalid), 64'(0));
                chk("mid_rst_busy", 64'(busy), 64'(0));
                chk("mid_rst_done", 64'(wr_done_vld), 64'(0));
                chk("mid_rst_pop", 64'(wdf_pop_rdy), 64'(0));
            end else begin
                if (m_axi_wvalid && m_axi_wready) acc++;
                if (wdf_pop_rdy && beat_q.size() > 0) void'(beat_q.pop_front());
            end
            tick();
        end
        chk("mid_rst_reached", 64'(hit), 64'(1));
        preset = 1'b0;
        idle_inputs();
        beat_q.delete();
        exp_q.delete();
        push_aw(9, 0);
        beat_q.push_back(mk_beat(9, 32'h99999999, 4'h3));
        exp_q.push_back(mk_beat(9, 32'h99999999, 4'h3));
        run_stream(1, 9, 1'b0);

`ifdef APB2AXI_W_TAG_CHECK_EN
        // Tag check: beat with tag 6 is dropped, beat with tag 5 is emitted.
        do_reset();
        push_aw(5, 0);
        tick();
        wdf_pop_vld = 1'b1;
        wdf_pop_payload = mk_beat(6, 32'h66666666, 4'hF);
        #1;
        chk("tc_drop_pop", 64'(wdf_pop_rdy), 64'(1));
        tick();
        wdf_pop_payload = mk_beat(5, 32'h55555555, 4'hF);
        #1;
        chk("tc_err_set", 64'(err_mismatch), 64'(1));
        chk("tc_no_beat", 64'(m_axi_wvalid), 64'(0));
        chk("tc_good_pop", 64'(wdf_pop_rdy), 64'(1));
        tick();
        wdf_pop_vld = 1'b0;
        #1;
        chk("tc_wvalid", 64'(m_axi_wvalid), 64'(1));
        chk("tc_wdata", 64'(m_axi_wdata), 64'(32'h55555555));
        chk("tc_wlast", 64'(m_axi_wlast), 64'(1));
        chk("tc_done_tag", 64'(wr_done_tag), 64'(5));
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        chk("tc_err_clr", 64'(err_mismatch), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
